// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bus bundle between the MEM/WB stage / decode stage and the
// writeback register bank.
//   Result, RdWb, Wrenable : writeback data, destination index, strobe
//   RaA, RaB, RdEn         : read addresses for ports A/B, shared read enable
//   DataA, DataB           : registered read data
//   Ready                  : bank has finished clearing and accepts accesses
interface wb_regfile_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic [DW-1:0] Result;
    logic [AW-1:0] RdWb;
    logic          Wrenable;
    logic [AW-1:0] RaA;
    logic [AW-1:0] RaB;
    logic          RdEn;
    logic [DW-1:0] DataA;
    logic [DW-1:0] DataB;
    logic          Ready;

    modport master (
        output Result, RdWb, Wrenable, RaA, RaB, RdEn,
        input  DataA, DataB, Ready
    );

    modport slave (
        input  Result, RdWb, Wrenable, RaA, RaB, RdEn,
        output DataA, DataB, Ready
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback-side register bank with two registered read ports.
// After reset a sequencer zeroes one entry per cycle, then raises Ready.
// Reads issued in the same cycle as a matching writeback see the new value.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous reset, active low
//   bus : wb_regfile_if.slave (writeback inputs, read addresses, read data,
//         Ready)
module wb_regfile #(
    parameter int NREGS = 128,
    parameter int AW    = 7,
    parameter int DW    = 32
) (
    input  logic         clk,
    input  logic         rst,
    wb_regfile_if.slave  bus
);
    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    // One extra bit so NREGS == 2**AW still compares correctly.
    localparam logic [AW:0]   LIMIT = (AW + 1)'(NREGS);
    localparam logic [AW-1:0] LAST  = AW'(NREGS - 1);

    state_t        state;
    logic [AW-1:0] ptr;
    logic [DW-1:0] mem [NREGS];
    logic          wr_ok;

    assign wr_ok = bus.Wrenable && (bus.RdWb != '0) && ({1'b0, bus.RdWb} < LIMIT);

    // Index 0 and out-of-range read as zero; a same-cycle writeback wins
    // over the stored entry.
    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ra);
        if (ra == '0 || {1'b0, ra} >= LIMIT) begin
            return '0;
        end
        if (bus.Wrenable && bus.RdWb == ra) begin
            return bus.Result;
        end
        return mem[ra];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= CLEAR;
            ptr       <= '0;
            bus.Ready <= 1'b0;
            bus.DataA <= '0;
            bus.DataB <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    mem[ptr] <= '0;
                    ptr      <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state     <= RUN;
                        bus.Ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr_ok) begin
                        mem[bus.RdWb] <= bus.Result;
                    end
                    if (bus.RdEn) begin
                        bus.DataA <= read_port(bus.RaA);
                        bus.DataB <= read_port(bus.RaB);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed bench for wb_regfile. A second instance with
// NREGS=100 shares all inputs and covers the out-of-range index behaviour.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    wb_regfile_if #(.AW(7), .DW(32)) bus1 ();
    wb_regfile_if #(.AW(7), .DW(32)) bus2 ();

    assign bus2.Result   = bus1.Result;
    assign bus2.RdWb     = bus1.RdWb;
    assign bus2.Wrenable = bus1.Wrenable;
    assign bus2.RaA      = bus1.RaA;
    assign bus2.RaB      = bus1.RaB;
    assign bus2.RdEn     = bus1.RdEn;

    wb_regfile #(.NREGS(128), .AW(7), .DW(32)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    wb_regfile #(.NREGS(100), .AW(7), .DW(32)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [6:0] rd, input logic [31:0] res,
                         input logic re, input logic [6:0] ra, input logic [6:0] rb);
        bus1.Wrenable = we;
        bus1.RdWb     = rd;
        bus1.Result   = res;
        bus1.RdEn     = re;
        bus1.RaA      = ra;
        bus1.RaB      = rb;
    endtask

    initial begin
        drive(1'b0, 7'd0, 32'h0, 1'b0, 7'd0, 7'd0);

        // Reset held for 3 edges
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("rst_ready", {31'b0, bus1.Ready}, 32'd0);
        check("rst_dataA", bus1.DataA, 32'h0);
        check("rst_dataB", bus1.DataB, 32'h0);
        check("rst_ready2", {31'b0, bus2.Ready}, 32'd0);

        // Release; write/read attempts during CLEAR, including the Ready edge
        rst = 1'b1;
        drive(1'b1, 7'd7, 32'hA5A5A5A5, 1'b1, 7'd7, 7'd7);
        for (int i = 1; i <= 128; i++) begin
            step();
            check($sformatf("clr_ready_%0d", i), {31'b0, bus1.Ready}, (i == 128) ? 32'd1 : 32'd0);
            check($sformatf("clr_dataA_%0d", i), bus1.DataA, 32'h0);
            check($sformatf("clr_dataB_%0d", i), bus1.DataB, 32'h0);
            check($sformatf("clr_ready2_%0d", i), {31'b0, bus2.Ready}, (i >= 100) ? 32'd1 : 32'd0);
        end

        // Write attempted during CLEAR did not land
        drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd7, 7'd0);
        step();
        check("clr_ignored_7", bus1.DataA, 32'h0);

        // Write then read
        drive(1'b1, 7'd5, 32'hDEADBEEF, 1'b0, 7'd0, 7'd0);
        step();
        drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd5, 7'd0);
        step();
        check("wr_rd_5", bus1.DataA, 32'hDEADBEEF);

        // Same-cycle bypass on both ports
        drive(1'b1, 7'd9, 32'h12345678, 1'b1, 7'd9, 7'd9);
        step();
        check("byp_A", bus1.DataA, 32'h12345678);
        check("byp_B", bus1.DataB, 32'h12345678);
        drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd5, 7'd9);
        step();
        check("arr_A5", bus1.DataA, 32'hDEADBEEF);
        check("arr_B9", bus1.DataB, 32'h12345678);

        // Back-to-back writes to one index, read each cycle
        drive(1'b1, 7'd11, 32'h11111111, 1'b1, 7'd11, 7'd5);
        step();
        check("b2b_1", bus1.DataA, 32'h11111111);
        drive(1'b1, 7'd11, 32'h22222222, 1'b1, 7'd11, 7'd5);
        step();
        check("b2b_2", bus1.DataA, 32'h22222222);
        drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd11, 7'd5);
        step();
        check("b2b_last", bus1.DataA, 32'h22222222);

        // Index zero: write discarded, bypass suppressed
        drive(1'b1, 7'd0, 32'hFFFFFFFF, 1'b0, 7'd0, 7'd0);
        step();
        drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd0, 7'd0);
        step();
        check("zero_rd", bus1.DataA, 32'h0);
        drive(1'b1, 7'd0, 32'hFFFFFFFF, 1'b1, 7'd0, 7'd0);
        step();
        check("zero_byp", bus1.DataA, 32'h0);

        // Range on the NREGS=100 bank; 120 is in range for the 128 bank
        drive(1'b1, 7'd120, 32'hCAFEF00D, 1'b0, 7'd0, 7'd0);
        step();
        drive(1'b1, 7'd99, 32'h0BADF00D, 1'b0, 7'd0, 7'd0);
        step();
        drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd99, 7'd120);
        step();
        check("range_B120_n100", bus2.DataB, 32'h0);
        check("range_A99_n100", bus2.DataA, 32'h0BADF00D);
        check("range_B120_n128", bus1.DataB, 32'hCAFEF00D);
        drive(1'b1, 7'd100, 32'h77777777, 1'b1, 7'd100, 7'd100);
        step();
        check("range_byp100_n100", bus2.DataA, 32'h0);
        check("range_byp100_n128", bus1.DataB, 32'h77777777);

        // Hold with RdEn low
        drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd5, 7'd9);
        step();
        check("hold_pre", bus1.DataA, 32'hDEADBEEF);
        drive(1'b1, 7'd5, 32'h55555555, 1'b0, 7'd9, 7'd11);
        step();
        check("hold_A", bus1.DataA, 32'hDEADBEEF);
        check("hold_B", bus1.DataB, 32'h12345678);
        drive(1'b0, 7'd0, 32'h0, 1'b0, 7'd11, 7'd0);
        step();
        check("hold_A2", bus1.DataA, 32'hDEADBEEF);

        // Reset mid-operation
        rst = 1'b0;
        step();
        check("mid_ready", {31'b0, bus1.Ready}, 32'd0);
        check("mid_dataA", bus1.DataA, 32'h0);
        check("mid_dataB", bus1.DataB, 32'h0);
        rst = 1'b1;
        for (int i = 1; i <= 128; i++) begin
            step();
            check($sformatf("reclr_ready_%0d", i), {31'b0, bus1.Ready}, (i == 128) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd5, 7'd9);
        step();
        check("reclr_A5", bus1.DataA, 32'h0);
        check("reclr_B9", bus1.DataB, 32'h0);
        drive(1'b0, 7'd0, 32'h0, 1'b1, 7'd11, 7'd120);
        step();
        check("reclr_A11", bus1.DataA, 32'h0);
        check("reclr_B120", bus1.DataB, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side register bank that consumes the MEM/WB pipeline register outputs (`Result`, `RdWb`, `Wrenable`) and commits them to architectural state. It provides two registered read ports for the decode stage, with write-to-read bypass so a value retiring in WB is visible to a read issued in the same cycle. After reset, an internal clear sequencer zeroes every entry one per cycle before asserting `Ready`, so the array maps onto block RAM.

## Interface

Parameters:

- `NREGS`, 128: number of entries; address space is `AW` bits wide.
- `AW`, 7: address width; matches the `RdWb` width of MEM/WB.
- `DW`, 32: data width; matches the `Result` width of MEM/WB.

Ports:

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `Result` in DW: writeback data from MEM/WB.
- `RdWb` in AW: writeback destination index from MEM/WB.
- `Wrenable` in 1: writeback strobe from MEM/WB.
- `RaA` in AW: read address, port A.
- `RaB` in AW: read address, port B.
- `RdEn` in 1: read enable, shared by both ports.
- `DataA` out DW: registered read data, port A.
- `DataB` out DW: registered read data, port B.
- `Ready` out 1: high once the clear sequence is complete and the bank is accepting reads and writes.

## Operation

- States are CLEAR and RUN, plus an internal clear pointer `ptr` of width AW.
- While `rst`=0 at a rising edge:
  - state goes to CLEAR, `ptr` goes to 0;
  - `Ready`, `DataA` and `DataB` go to 0;
  - the array is not written.
- CLEAR with `rst`=1, at each edge:
  - entry[`ptr`] <= 0 and `ptr` <= `ptr`+1;
  - `Wrenable` and `RdEn` are ignored;
  - `DataA`/`DataB` hold at 0.
- CLEAR exit: on the edge where `ptr`==NREGS-1, the last entry is cleared, state goes to RUN and `Ready` goes to 1.
- RUN, write: an edge with `Wrenable`=1, `RdWb`!=0 and `RdWb`<NREGS writes entry[`RdWb`] <= `Result`. Index 0 and out-of-range indices are discarded silently.
- RUN, read: an edge with `RdEn`=1 updates each port independently, in this priority order:
  - `Ra`==0 or `Ra`>=NREGS gives 0;
  - otherwise, if `Wrenable`=1 and `RdWb`==`Ra`, gives `Result` (bypass);
  - otherwise gives entry[`Ra`].
- RUN with `RdEn`=0: `DataA`/`DataB` hold their previous values.
- Entry 0 always reads as 0, whatever its stored contents.
- `rst`=0 in RUN (reset mid-operation) re-enters CLEAR.
  - `Ready` drops to 0 on that edge.
  - All entries are re-zeroed once `rst` returns high; no old contents survive.

## Timing

- Read latency is 1 cycle: address and `RdEn` sampled at edge N give data valid after edge N.
- Write latency is 1 cycle: a write at edge N is visible to a read sampled at edge N (via bypass) and at any later edge (via the array).
- Clear duration: `Ready` rises exactly NREGS rising edges after the first edge with `rst`=1.
  - A write or read presented on the edge where `Ready` rises is ignored, because the state was still CLEAR.
  - The first accepted access is on the following edge.
- Simultaneous write and same-address read on both ports: both ports return `Result`.
- Back-to-back writes to the same index: the last write wins. A read in each cycle returns the value written in that cycle (bypass).
- No combinational path from any input to any output.

## Test plan

- Reset/clear: hold `rst`=0 for 3 edges, then release with NREGS=128. Required:
  - `Ready`=0 for edges 1..127 after release, `Ready`=1 after edge 128;
  - `DataA`=`DataB`=0 throughout.
- Write then read: after `Ready`, write `Result`=32'hDEADBEEF to `RdWb`=5. Next cycle, `RaA`=5, `RdEn`=1. Required: `DataA`=32'hDEADBEEF one cycle later.
- Bypass: in the same cycle, `Wrenable`=1, `RdWb`=9, `Result`=32'h12345678, `RaA`=`RaB`=9, `RdEn`=1. Required: `DataA`=`DataB`=32'h12345678 after that edge.
- Zero and range:
  - write 32'hFFFFFFFF to `RdWb`=0, then read `RaA`=0. Required: `DataA`=0.
  - With NREGS=100, write to `RdWb`=120, then read `RaB`=120. Required: `DataB`=0.
- Hold and reset mid-operation:
  - read index 5 (32'hDEADBEEF), then set `RdEn`=0 and change `RaA`. Required: `DataA` holds 32'hDEADBEEF.
  - Then pulse `rst`=0 for 1 edge. Required: `Ready`=0 and `DataA`=0 immediately, `Ready`=1 after 128 edges, and a read of index 5 returns 0.
- Ignored-during-clear: during CLEAR, drive `Wrenable`=1, `RdWb`=7, `Result`=32'hA5A5A5A5. After `Ready`, read index 7. Required: `DataA`=0.
